// File: rtl/rr_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_stream_arbiter
//  Purpose  : Round-robin arbiter sharing one WIDTH-bit valid/ready output
//             stream between N requesters.
//
//             The winner's word is routed through an N:1 selection and
//             captured in a one-entry registered output stage. The stage can
//             drain and capture a new word in the same cycle, so a single
//             word per cycle flows while out_ready_i is held high.
//
//  Ports    : clk_i        - clock, rising edge
//             rst_ni       - asynchronous active-low reset
//             req_valid_i  - per-requester valid        [N]
//             req_data_i   - per-requester data         [N] x WIDTH
//             req_ready_o  - per-requester ready, one-hot or zero (comb.)
//             out_valid_o  - output word valid          (registered)
//             out_data_o   - output word                (registered)
//             out_ready_i  - downstream ready
//             sel_o        - index of the held word's requester (registered)
//
//  Revision : 1.0 - initial release
// ============================================================================
module rr_stream_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_valid_i,
  input  logic [WIDTH-1:0] req_data_i [N],
  output logic [N-1:0]     req_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [SELW-1:0]  sel_o
);

  // Value of the round-robin pointer out of reset: the last requester,
  // so that requester 0 holds first priority.
  localparam logic [SELW-1:0] c_LAST_RST = SELW'(N - 1);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_sel;
  logic [SELW-1:0]  r_last;

  logic             w_load;
  logic             w_hi_found;
  logic [SELW-1:0]  w_hi_idx;
  logic             w_lo_found;
  logic [SELW-1:0]  w_lo_idx;
  logic             w_any;
  logic [SELW-1:0]  w_win;
  logic             w_grant;

  // Output stage can accept a word when empty or draining this cycle.
  assign w_load = !r_valid || out_ready_i;

  // Rotating priority without a modulo: the lowest valid index strictly
  // above the pointer wins; failing that, the lowest valid index at or below
  // it (the wrapped part). This keeps the winner < N for any N.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req_valid_i[j]) begin
        if (j > int'(r_last)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = SELW'(j);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = SELW'(j);
        end
      end
    end
  end

  assign w_any   = w_hi_found || w_lo_found;
  assign w_win   = w_hi_found ? w_hi_idx : w_lo_idx;
  // Gated with rst_ni so no handshake can be signalled while held in reset
  // (the async reset forces r_valid low, which would otherwise open load).
  assign w_grant = rst_ni && w_load && w_any;

  always_comb begin
    req_ready_o = '0;
    for (int j = 0; j < N; j++) begin
      req_ready_o[j] = w_grant && (w_win == SELW'(j));
    end
  end

  // Output stage and pointer. The pointer moves only on a completed grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_last  <= c_LAST_RST;
    end else if (w_load) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= req_data_i[w_win];
        r_sel   <= w_win;
        r_last  <= w_win;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;
  assign sel_o       = r_sel;

endmodule
`default_nettype wire
